// File: rtl/layer_seq_ctrl_if.sv
// Result stream of layer_seq_ctrl: one captured neuron output per beat,
// tagged with its neuron index, under a valid/ready handshake.
interface layer_seq_ctrl_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_NEURONS = 30
);
   logic [DATA_WIDTH-1:0]          out_data;
   logic [$clog2(NUM_NEURONS)-1:0] out_idx;
   logic                           out_valid;
   logic                           out_ready;

   modport master (output out_data, output out_idx, output out_valid, input out_ready);
   modport slave  (input out_data, input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully connected layer: bursts the activation vector to all
// neurons, captures their outputs, then drains them on a valid/ready stream.
// Optional WAIT timeout with sticky err: define LAYER_SEQ_CTRL_TIMEOUT_EN.
module layer_seq_ctrl #(
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_NEURONS = 30,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_LIMIT  = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              in_rd_en,
   output logic [$clog2(NUM_INPUTS)-1:0]     in_rd_addr,
   input  logic [DATA_WIDTH-1:0]             in_rd_data,
   output logic [DATA_WIDTH-1:0]             neuron_in,
   output logic                              neuron_in_valid,
   input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
   input  logic [NUM_NEURONS-1:0]            neuron_outvalid,
   layer_seq_ctrl_if.master                  stream,
   output logic                              err
);

   localparam int AW = $clog2(NUM_INPUTS);
   localparam int IW = $clog2(NUM_NEURONS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] cap      [NUM_NEURONS];
   logic [DATA_WIDTH-1:0] cap_next [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] flag;
   logic [NUM_NEURONS-1:0] flag_next;
   logic                  all_set;
   logic [IW-1:0]         idx_inc;

   // Capture view including this cycle's pulses, so WAIT can leave on the same
   // cycle the last flag sets and DRAIN loads values that arrive on that edge.
   always_comb begin
      cap_next  = cap;
      flag_next = flag;
      if (state != S_IDLE) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            if (neuron_outvalid[k]) begin
               cap_next[k]  = neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
               flag_next[k] = 1'b1;
            end
         end
      end
   end

   assign all_set   = &flag_next;
   assign idx_inc   = stream.out_idx + IW'(1);
   assign neuron_in = in_rd_data;

`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(WAIT_LIMIT + 1);
   logic [CW-1:0] wait_cnt;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         in_rd_en         <= 1'b0;
         in_rd_addr       <= '0;
         neuron_in_valid  <= 1'b0;
         stream.out_valid <= 1'b0;
         stream.out_idx   <= '0;
         stream.out_data  <= '0;
         flag             <= '0;
         cap              <= '{default: '0};
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
         err              <= 1'b0;
         wait_cnt         <= '0;
`endif
      end else begin
         cap             <= cap_next;
         flag            <= flag_next;
         neuron_in_valid <= in_rd_en;
         done            <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_STREAM;
                  busy       <= 1'b1;
                  in_rd_en   <= 1'b1;
                  in_rd_addr <= '0;
                  flag       <= '0;
                  // Cleared too so a neuron that never fires drains as zero.
                  cap        <= '{default: '0};
               end
            end
            S_STREAM: begin
               if (in_rd_addr == LAST_ADDR) begin
                  state      <= S_WAIT;
                  in_rd_en   <= 1'b0;
                  in_rd_addr <= '0;
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
                  wait_cnt   <= '0;
`endif
               end else begin
                  in_rd_addr <= in_rd_addr + AW'(1);
               end
            end
            S_WAIT: begin
               if (all_set) begin
                  state            <= S_DRAIN;
                  stream.out_valid <= 1'b1;
                  stream.out_idx   <= '0;
                  stream.out_data  <= cap_next[0];
               end
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
               else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                  err              <= 1'b1;
                  state            <= S_DRAIN;
                  stream.out_valid <= 1'b1;
                  stream.out_idx   <= '0;
                  stream.out_data  <= cap_next[0];
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
`endif
            end
            S_DRAIN: begin
               if (stream.out_ready) begin
                  if (stream.out_idx == LAST_IDX) begin
                     state            <= S_DONE;
                     done             <= 1'b1;
                     stream.out_valid <= 1'b0;
                     stream.out_idx   <= '0;
                     stream.out_data  <= '0;
                  end else begin
                     stream.out_idx  <= idx_inc;
                     stream.out_data <= cap_next[idx_inc];
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl: a pass-relative timing model predicts
// every output each cycle; fixed scenarios pin the model with literal values.
module tb_layer_seq_ctrl;

   localparam int NI = 4;
   localparam int NN = 3;
   localparam int DW = 16;
   localparam int WL = 8;
   localparam int AW = $clog2(NI);
   localparam int IW = $clog2(NN);

   logic               clk;
   logic               rst;
   logic               start;
   logic               busy;
   logic               done;
   logic               in_rd_en;
   logic [AW-1:0]      in_rd_addr;
   logic [DW-1:0]      in_rd_data;
   logic [DW-1:0]      neuron_in;
   logic               neuron_in_valid;
   logic [NN*DW-1:0]   neuron_out;
   logic [NN-1:0]      neuron_outvalid;
   logic               err;

   layer_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) stream_if ();

   layer_seq_ctrl #(
      .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
      .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
      .stream(stream_if), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [NI];
   int            f1 [NN];
   int            f2 [NN];
   logic [DW-1:0] v1 [NN];
   logic [DW-1:0] v2 [NN];
   int            ready_mode;
   bit            start_noise;

   int            m_rd;
   int            m_j;
   int            m_th;
   int            m_stall;
   bit            m_timed_out;
   bit            m_prev_en;
   logic [AW-1:0] m_prev_addr;
   logic [DW-1:0] m_exp [NN];
   bit            err_sticky;

   int            got_n;
   int            got_idx  [NN];
   logic [DW-1:0] got_data [NN];
   int            done_r;
   int            first_ov_r;

   int            n_checks;
   int            n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"},      32'(busy), 32'(0));
      check({tag, " done"},      32'(done), 32'(0));
      check({tag, " in_rd_en"},  32'(in_rd_en), 32'(0));
      check({tag, " in_rd_addr"}, 32'(in_rd_addr), 32'(0));
      check({tag, " n_in_valid"}, 32'(neuron_in_valid), 32'(0));
      check({tag, " out_valid"}, 32'(stream_if.out_valid), 32'(0));
      check({tag, " out_idx"},   32'(stream_if.out_idx), 32'(0));
      check({tag, " out_data"},  32'(stream_if.out_data), 32'(0));
      check({tag, " err"},       32'(err), 32'(0));
   endtask

   // Drives one cycle of inputs for pass-relative cycle r (r=0 carries start).
   task automatic apply_stimulus(input int r);
      start = (r == 0) || (start_noise && $urandom_range(0, 2) == 0);
      in_rd_data = m_prev_en ? mem[m_prev_addr] : DW'($urandom);
      neuron_out = (NN*DW)'({$urandom(), $urandom()});
      neuron_outvalid = '0;
      for (int k = 0; k < NN; k++) begin
         if (r == f1[k]) begin
            neuron_outvalid[k] = 1'b1;
            neuron_out[k*DW +: DW] = v1[k];
         end
         if (r == f2[k]) begin
            neuron_outvalid[k] = 1'b1;
            neuron_out[k*DW +: DW] = v2[k];
         end
      end
      case (ready_mode)
         0: stream_if.out_ready = 1'b1;
         1: stream_if.out_ready = 1'($urandom_range(0, 1));
         default: begin
            if (m_j == 1 && m_stall > 0) begin
               stream_if.out_ready = 1'b0;
               m_stall--;
            end else begin
               stream_if.out_ready = 1'b1;
            end
         end
      endcase
   endtask

   // Compares every output against the pass model for cycle r.
   task automatic check_output(input int r);
      bit exp_en;
      bit exp_niv;
      bit exp_ov;
      m_prev_en   = in_rd_en;
      m_prev_addr = in_rd_addr;
      exp_en  = (r >= 1 && r <= NI);
      exp_niv = (r >= 2 && r <= NI + 1);
      exp_ov  = (r >= m_rd && m_th < 0);
      check("busy", 32'(busy), 32'(r >= 1));
      check("done", 32'(done), 32'(m_th >= 0 && r == m_th + 1));
      check("in_rd_en", 32'(in_rd_en), 32'(exp_en));
      if (exp_en) check("in_rd_addr", 32'(in_rd_addr), 32'(r - 1));
      check("neuron_in_valid", 32'(neuron_in_valid), 32'(exp_niv));
      if (exp_niv) check("neuron_in", 32'(neuron_in), 32'(mem[r-2]));
      check("out_valid", 32'(stream_if.out_valid), 32'(exp_ov));
      if (exp_ov) begin
         check("out_idx", 32'(stream_if.out_idx), 32'(m_j));
         check("out_data", 32'(stream_if.out_data), 32'(m_exp[m_j]));
      end
      if (m_timed_out && r >= m_rd) err_sticky = 1'b1;
      check("err", 32'(err), 32'(err_sticky));
      if (stream_if.out_valid && first_ov_r < 0) first_ov_r = r;
      if (exp_ov && stream_if.out_ready) begin
         got_idx[m_j]  = int'(stream_if.out_idx);
         got_data[m_j] = stream_if.out_data;
         got_n++;
         if (m_j == NN - 1) m_th = r;
         m_j++;
      end
   endtask

   task automatic run_pass();
      int  t_all;
      bit  finished;
      t_all = 0;
      for (int k = 0; k < NN; k++)
         t_all = (f1[k] < 0) ? 1000000 : ((f1[k] > t_all) ? f1[k] : t_all);
      m_timed_out = 1'b0;
      m_rd = (t_all + 1 > NI + 2) ? t_all + 1 : NI + 2;
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
      if (t_all > NI + WL) begin
         m_timed_out = 1'b1;
         m_rd = NI + 1 + WL;
      end
`endif
      for (int k = 0; k < NN; k++)
         m_exp[k] = (f2[k] >= 0) ? v2[k] : ((f1[k] >= 0) ? v1[k] : '0);
      m_j = 0; m_th = -1; m_stall = 3; m_prev_en = 1'b0; m_prev_addr = '0;
      got_n = 0; done_r = -1; first_ov_r = -1; finished = 1'b0;
      for (int r = 0; r < 400; r++) begin
         @(posedge clk); #1;
         apply_stimulus(r);
         @(negedge clk);
         check_output(r);
         if (m_th >= 0 && r == m_th + 1) begin
            done_r = r;
            finished = 1'b1;
            break;
         end
      end
      check("pass completes within bound", 32'(finished), 32'(1));
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         neuron_outvalid = '0;
         @(negedge clk);
         check("idle busy", 32'(busy), 32'(0));
         check("idle out_valid", 32'(stream_if.out_valid), 32'(0));
         check("idle in_rd_en", 32'(in_rd_en), 32'(0));
      end
   endtask

   task automatic check_stream_literal(input string tag, input logic [DW-1:0] d0,
                                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      check({tag, " beats"}, 32'(got_n), 32'(3));
      check({tag, " idx0"}, 32'(got_idx[0]), 32'(0));
      check({tag, " idx1"}, 32'(got_idx[1]), 32'(1));
      check({tag, " idx2"}, 32'(got_idx[2]), 32'(2));
      check({tag, " data0"}, 32'(got_data[0]), 32'(d0));
      check({tag, " data1"}, 32'(got_data[1]), 32'(d1));
      check({tag, " data2"}, 32'(got_data[2]), 32'(d2));
   endtask

   task automatic reset_mid_stream();
      bit found;
      found = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      neuron_outvalid = '0;
      stream_if.out_ready = 1'b1;
      for (int c = 0; c < 8 && !found; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         if (in_rd_en && in_rd_addr == AW'(2)) found = 1'b1;
      end
      check("reached address 2", 32'(found), 32'(1));
      #2 rst = 1'b0;
      #1 check_reset_outputs("async reset");
      @(posedge clk); #3;
      rst = 1'b1;
      err_sticky = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t_all;
      n_checks = 0; n_fail = 0; err_sticky = 1'b0;
      rst = 1'b0; start = 1'b0; in_rd_data = '0; neuron_out = '0;
      neuron_outvalid = '0; stream_if.out_ready = 1'b0;
      ready_mode = 0; start_noise = 1'b0;
      m_prev_en = 1'b0; m_prev_addr = '0; m_j = 0;
      #12 check_reset_outputs("reset");
      @(negedge clk) rst = 1'b1;
      idle_cycles(2);

      // Basic pass: fire 5 cycles after the burst ends, expected length 14.
      mem = '{16'd1, 16'd2, 16'd3, 16'd4};
      f1 = '{10, 10, 10}; f2 = '{-1, -1, -1};
      v1 = '{16'h000A, 16'h000B, 16'h000C}; v2 = '{16'h0, 16'h0, 16'h0};
      run_pass();
      check_stream_literal("basic", 16'h000A, 16'h000B, 16'h000C);
      check("basic first out_valid cycle", 32'(first_ov_r), 32'(11));
      check("basic done cycle", 32'(done_r), 32'(14));

      // Neuron 2 first, then 0 and 1 together; starts the cycle after done.
      f1 = '{9, 9, 7};
      v1 = '{16'h0021, 16'h0022, 16'h0023};
      run_pass();
      check_stream_literal("out-of-order", 16'h0021, 16'h0022, 16'h0023);
      check("out-of-order drain cycle", 32'(first_ov_r), 32'(10));

      // Three cycles of out_ready low while idx 1 is presented.
      f1 = '{8, 8, 8};
      v1 = '{16'h0031, 16'h0032, 16'h0033};
      ready_mode = 2;
      run_pass();
      check_stream_literal("backpressure", 16'h0031, 16'h0032, 16'h0033);
      check("backpressure done cycle", 32'(done_r), 32'(15));

      // Stray starts during STREAM, WAIT, DRAIN and DONE.
      f1 = '{10, 10, 10};
      v1 = '{16'h0041, 16'h0042, 16'h0043};
      ready_mode = 0; start_noise = 1'b1;
      run_pass();
      check("stray start done cycle", 32'(done_r), 32'(14));
      start_noise = 1'b0;

      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < NI; i++) mem[i] = DW'($urandom);
         t_all = 0;
         for (int k = 0; k < NN; k++) begin
            f1[k] = int'($urandom_range(1, NI + WL));
            v1[k] = DW'($urandom);
            if (f1[k] > t_all) t_all = f1[k];
         end
         for (int k = 0; k < NN; k++) begin
            if (f1[k] < t_all && $urandom_range(0, 1) == 1) begin
               f2[k] = int'($urandom_range(f1[k] + 1, t_all));
               v2[k] = DW'($urandom);
            end else begin
               f2[k] = -1;
            end
         end
         ready_mode  = int'($urandom_range(0, 2));
         start_noise = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
         run_pass();
      end

      // Abort mid-burst, then a clean full pass from address 0.
      start_noise = 1'b0; ready_mode = 0;
      mem = '{16'd5, 16'd6, 16'd7, 16'd8};
      f1 = '{10, 10, 10}; f2 = '{-1, -1, -1};
      v1 = '{16'h0051, 16'h0052, 16'h0053};
      reset_mid_stream();
      run_pass();
      check_stream_literal("after reset", 16'h0051, 16'h0052, 16'h0053);

`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
      // Neuron 1 never fires: drain after WL wait cycles with a zero slot.
      f1 = '{6, -1, 7};
      v1 = '{16'h0011, 16'h0022, 16'h0033};
      run_pass();
      check_stream_literal("timeout", 16'h0011, 16'h0000, 16'h0033);
      check("timeout drain cycle", 32'(first_ov_r), 32'(13));
      check("timeout done cycle", 32'(done_r), 32'(16));
      check("timeout err", 32'(err), 32'(1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
